tx_frame_scheduler: RTL and testbench
=====================================

TX_FRAME_SCHEDULER -- requirements
Module: tx_frame_scheduler

Interface
REQ-001 Parameter IFG_CYCLES, default 8, idle clk cycles inserted between the end of one frame and the next enable.
REQ-002 Parameter START_TIMEOUT, default 4, max cycles allowed after tx_enable rises for tx_complete to fall.
REQ-003 Parameter BUSY_TIMEOUT, default 63, max cycles allowed in BUSY for tx_complete to return high.
REQ-004 clk  input  1  sole clock; all logic updates on its rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 req_valid  input  2  per-requester frame request; index 0 = data, 1 = control.
REQ-007 req_data0 / req_data1  input  36  per-requester payload (post-CRC transmit bits).
REQ-008 req_ready  output  2  one-cycle acceptance pulse to the granted requester.
REQ-009 tx_enable  output  1  drives the transmitter enable.
REQ-010 tx_bits  output  36  payload held stable to the transmitter.
REQ-011 tx_complete  input  1  transmitter completion flag; 1 = idle, 0 = frame in flight.
REQ-012 frame_done  output  1  one-cycle pulse when a frame finishes normally.
REQ-013 done_id  output  1  requester index of the frame; valid with frame_done or err_pulse.
REQ-014 err_pulse  output  1  one-cycle pulse on either timeout.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, START, BUSY, GAP.
REQ-017 IDLE: if any req_valid and tx_complete==1, grant one requester, latch its payload into tx_bits, pulse its req_ready, set done_id, go to START.
REQ-018 Arbitration is round-robin; the pointer favours the requester not granted last; after reset requester 0 is favoured.
REQ-019 A single valid requester is granted regardless of the pointer; the pointer updates only on a grant.
REQ-020 Simultaneous valid on both requesters: exactly one req_ready bit may be high in any cycle.
REQ-021 IDLE with tx_complete==0 (transmitter still busy): no grant; remain in IDLE.
REQ-022 START: tx_enable=1; on tx_complete==0 go to BUSY and drop tx_enable in the same transition, so tx_enable is 0 in the first BUSY cycle.
REQ-023 START timeout: if tx_complete stays 1 for START_TIMEOUT cycles, drop tx_enable, pulse err_pulse, go to GAP.
REQ-024 BUSY: tx_enable=0; on tx_complete==1 pulse frame_done and go to GAP.
REQ-025 BUSY timeout: after BUSY_TIMEOUT cycles without tx_complete==1, pulse err_pulse (no frame_done) and go to GAP.
REQ-026 GAP: count exactly IFG_CYCLES cycles, then go to IDLE; IFG_CYCLES=0 means go directly to IDLE on the next cycle.
REQ-027 tx_bits is held constant from grant until the next grant.
REQ-028 A single 6-bit cycle counter is shared by START, BUSY and GAP and cleared on every state entry; BUSY_TIMEOUT is at most 63.
REQ-029 req_valid is ignored outside IDLE; requests are never queued internally.
REQ-030 Grant-to-tx_enable latency is 1 cycle: req_ready in cycle N, tx_enable high in cycle N+1.

Reset
REQ-031 rst takes priority over all other inputs and forces state=IDLE, counter=0, arbitration pointer favouring requester 0, and all outputs to 0, including tx_bits.
REQ-032 rst asserted mid-frame drops tx_enable on the next edge; the in-flight frame gets no frame_done or err_pulse.

Structure
REQ-033 A shared package holds the FSM state encoding, the payload width (36), and the requester count (2).
REQ-034 The round-robin arbiter is a separate sub-module, rr_arbiter2, with inputs req[1:0] and advance, and output grant[1:0], one-hot or zero.

Verification
REQ-035 Single frame: req_valid=01, data0=36'h123456789; transmitter model drops tx_complete 1 cycle after enable and restores it after 44 cycles -> req_ready=01; tx_bits=123456789; one frame_done with done_id=0; busy asserted through the 8 GAP cycles.
REQ-036 Contention: req_valid=11 held for 4 frames -> grants 0,1,0,1; never both req_ready bits high.
REQ-037 START timeout: tx_complete tied to 1 -> tx_enable high for 4 cycles; err_pulse; no frame_done; IDLE after the GAP.
REQ-038 BUSY timeout: tx_complete held at 0 after the drop -> err_pulse 63 cycles after BUSY entry; tx_enable stays 0.
REQ-039 Mid-frame reset: rst pulsed in BUSY -> next cycle all outputs 0, state IDLE; the next request is granted to requester 0.
REQ-040 Back-to-back: req_valid held continuously -> exactly IFG_CYCLES cycles with busy=1 and tx_enable=0 between frame_done and the next req_ready.

Source files
------------

// File: rtl/tx_frame_scheduler_pkg.sv
// Shared definitions for the transmit frame scheduler: state encoding,
// payload/requester sizing and the shared cycle counter width.
package tx_frame_scheduler_pkg;

    localparam int PAYLOAD_W = 36;
    localparam int NUM_REQ   = 2;
    localparam int CNT_W     = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    // Index of a one-hot two-requester grant (zero grant maps to index 0).
    function automatic logic grant_index(input logic [NUM_REQ-1:0] grant);
        return grant[1];
    endfunction

endpackage

// File: rtl/tx_frame_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter: the pointer favours whichever requester
// lost the most recent grant; a lone requester always wins.
module rr_arbiter2
    import tx_frame_scheduler_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

    logic ptr_r;
    logic [NUM_REQ-1:0] grant_s;

    // Pick a single winner from the current requests.
    always_comb begin
        grant_s = 2'b00;
        case (req)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = ptr_r ? 2'b10 : 2'b01;
            default: grant_s = 2'b00;
        endcase
    end

    assign grant = grant_s;

    // Move the pointer to the non-granted requester whenever a grant is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= 1'b0;
        end else if (advance && (grant_s != 2'b00)) begin
            ptr_r <= ~grant_index(grant_s);
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Grants one of two frame requesters, drives the transmitter enable handshake
// with start/busy timeouts, and enforces an inter-frame gap.
module tx_frame_scheduler
    import tx_frame_scheduler_pkg::*;
#(
    parameter int IFG_CYCLES    = 8,
    parameter int START_TIMEOUT = 4,
    parameter int BUSY_TIMEOUT  = 63
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [PAYLOAD_W-1:0] req_data0,
    input  logic [PAYLOAD_W-1:0] req_data1,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_enable,
    output logic [PAYLOAD_W-1:0] tx_bits,
    input  logic                 tx_complete,
    output logic                 frame_done,
    output logic                 done_id,
    output logic                 err_pulse,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT);
    localparam logic [CNT_W-1:0] BUSY_LAST  = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(IFG_CYCLES - 1);
    localparam logic             GAP_NONE   = (IFG_CYCLES == 0);

    state_e state_r, next_state_s;
    logic [CNT_W-1:0] count_r;
    logic [NUM_REQ-1:0] grant_s;
    logic grant_ok_s, take_s;

    logic [NUM_REQ-1:0]   req_ready_s, req_ready_r;
    logic [PAYLOAD_W-1:0] tx_bits_s, tx_bits_r;
    logic tx_enable_s, tx_enable_r;
    logic frame_done_s, frame_done_r;
    logic err_pulse_s, err_pulse_r;
    logic done_id_s, done_id_r;
    logic busy_s, busy_r;

    // Requests are only visible to the arbiter while idle with the transmitter free.
    assign grant_ok_s = (state_r == ST_IDLE) && tx_complete;
    assign take_s     = (grant_s != 2'b00);

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid & {NUM_REQ{grant_ok_s}}),
        .advance (take_s),
        .grant   (grant_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a completion seen in the timeout cycle wins over the timeout.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (take_s) next_state_s = ST_START;
                else        next_state_s = ST_IDLE;
            end
            ST_START: begin
                if (!tx_complete)              next_state_s = ST_BUSY;
                else if (count_r == START_LAST) next_state_s = ST_GAP;
                else                           next_state_s = ST_START;
            end
            ST_BUSY: begin
                if (tx_complete)               next_state_s = ST_GAP;
                else if (count_r == BUSY_LAST) next_state_s = ST_GAP;
                else                           next_state_s = ST_BUSY;
            end
            ST_GAP: begin
                if (GAP_NONE || (count_r == GAP_LAST)) next_state_s = ST_IDLE;
                else                                   next_state_s = ST_GAP;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Shared cycle counter, cleared on every state entry and held at zero in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if ((next_state_s != state_r) || (state_r == ST_IDLE)) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    // Output values for the next cycle, derived from the current transition.
    always_comb begin
        req_ready_s  = 2'b00;
        tx_enable_s  = 1'b0;
        frame_done_s = 1'b0;
        err_pulse_s  = 1'b0;
        tx_bits_s    = tx_bits_r;
        done_id_s    = done_id_r;
        busy_s       = (next_state_s != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (take_s) begin
                    req_ready_s = grant_s;
                    tx_bits_s   = grant_index(grant_s) ? req_data1 : req_data0;
                    done_id_s   = grant_index(grant_s);
                end else begin
                    req_ready_s = 2'b00;
                end
            end
            ST_START: begin
                tx_enable_s = (next_state_s == ST_START);
                err_pulse_s = (next_state_s == ST_GAP);
            end
            ST_BUSY: begin
                frame_done_s = tx_complete;
                err_pulse_s  = (next_state_s == ST_GAP) && !tx_complete;
            end
            ST_GAP: begin
                tx_enable_s = 1'b0;
            end
            default: begin
                tx_enable_s = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready_r  <= 2'b00;
            tx_enable_r  <= 1'b0;
            tx_bits_r    <= '0;
            frame_done_r <= 1'b0;
            err_pulse_r  <= 1'b0;
            done_id_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            req_ready_r  <= req_ready_s;
            tx_enable_r  <= tx_enable_s;
            tx_bits_r    <= tx_bits_s;
            frame_done_r <= frame_done_s;
            err_pulse_r  <= err_pulse_s;
            done_id_r    <= done_id_s;
            busy_r       <= busy_s;
        end
    end

    assign req_ready  = req_ready_r;
    assign tx_enable  = tx_enable_r;
    assign tx_bits    = tx_bits_r;
    assign frame_done = frame_done_r;
    assign err_pulse  = err_pulse_r;
    assign done_id    = done_id_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Randomised self-checking bench for tx_frame_scheduler with a behavioural
// transmitter and a round-robin/outcome reference model.
module tb_tx_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [35:0] req_data0 = 36'd0;
    logic [35:0] req_data1 = 36'd0;
    logic        tx_complete = 1'b1;
    logic [1:0]  req_ready;
    logic        tx_enable;
    logic [35:0] tx_bits;
    logic        frame_done, done_id, err_pulse, busy;

    int n_cmp = 0;
    int n_fail = 0;
    logic model_fav = 1'b0;

    typedef struct {
        logic [1:0]  ready;
        logic [35:0] bits;
        logic        id;
        logic        evt_id;
        int wait_cyc, en_first, en_cnt, done_cnt, err_cnt, err_cyc, low_start, end_cyc, gap_busy;
        bit both, extra_ready, hold_bad, timed_out;
    } obs_t;

    always #5 clk = ~clk;

    tx_frame_scheduler #(.IFG_CYCLES(8), .START_TIMEOUT(4), .BUSY_TIMEOUT(63)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data0(req_data0), .req_data1(req_data1),
        .req_ready(req_ready), .tx_enable(tx_enable), .tx_bits(tx_bits), .tx_complete(tx_complete),
        .frame_done(frame_done), .done_id(done_id), .err_pulse(err_pulse), .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Round-robin reference: both requesting -> favoured one; else the lone requester.
    function automatic logic model_grant(input logic [1:0] rv);
        logic g;
        g = (rv == 2'b11) ? model_fav : rv[1];
        model_fav = ~g;
        return g;
    endfunction

    // Runs one frame: request, behavioural transmitter, observation until back in IDLE.
    // drop_after < 0: transmitter never starts; low_len < 0: transmitter never finishes.
    task automatic do_frame(input logic [1:0] rv, input logic [35:0] d0, input logic [35:0] d1,
                            input int drop_after, input int low_len, input bit hold, output obs_t o);
        bit gap_on;
        gap_on = 1'b0;
        o = '{default: 0};
        o.en_first = -1; o.err_cyc = -1; o.low_start = -1;
        req_valid = rv; req_data0 = d0; req_data1 = d1;
        for (int w = 1; w <= 16; w++) begin
            step();
            if (req_ready !== 2'b00) begin o.wait_cyc = w; break; end
        end
        if (o.wait_cyc == 0) begin
            o.timed_out = 1'b1;
            req_valid = 2'b00;
            return;
        end
        o.ready = req_ready; o.bits = tx_bits; o.id = done_id;
        if (!hold) req_valid = 2'b00;
        for (int c = 1; c <= 200; c++) begin
            step();
            if (req_ready === 2'b11) o.both = 1'b1;
            if (req_ready !== 2'b00) o.extra_ready = 1'b1;
            if (tx_bits !== o.bits) o.hold_bad = 1'b1;
            if (tx_enable === 1'b1) begin
                o.en_cnt++;
                if (o.en_first < 0) o.en_first = c;
            end
            if (frame_done === 1'b1) begin o.done_cnt++; o.evt_id = done_id; gap_on = 1'b1; end
            if (err_pulse === 1'b1) begin o.err_cnt++; o.evt_id = done_id; o.err_cyc = c; gap_on = 1'b1; end
            if (busy !== 1'b1) begin o.end_cyc = c; break; end
            if (gap_on && tx_enable === 1'b0) o.gap_busy++;
            if (o.en_first >= 0 && drop_after >= 0 && c == o.en_first + drop_after) begin
                tx_complete = 1'b0;
                o.low_start = c;
            end else if (o.low_start >= 0 && low_len >= 0 && c == o.low_start + low_len) begin
                tx_complete = 1'b1;
            end
        end
        if (o.end_cyc == 0) o.timed_out = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 2'b11; tx_complete = 1'b1;
        req_data0 = {4'($urandom), 32'($urandom)}; req_data1 = {4'($urandom), 32'($urandom)};
        repeat (3) step();
        n_cmp++;
        if ({req_ready, tx_enable, tx_bits, frame_done, done_id, err_pulse, busy} !== 43'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0",
                     {req_ready, tx_enable, tx_bits, frame_done, done_id, err_pulse, busy});
        end
        rst = 1'b0; req_valid = 2'b00; model_fav = 1'b0;
        repeat (2) step();
        n_cmp++;
        if ({req_ready, busy, tx_enable} !== 4'd0) begin
            n_fail++;
            $display("FAIL idle_no_request: got %b required 0000", {req_ready, busy, tx_enable});
        end
    endtask

    task automatic test_single_frame();
        obs_t o;
        logic id;
        id = model_grant(2'b01);
        do_frame(2'b01, 36'h123456789, {4'($urandom), 32'($urandom)}, 1, 44, 1'b0, o);
        n_cmp++;
        if (o.timed_out || o.ready !== 2'b01) begin
            n_fail++; $display("FAIL single_ready: got %b timeout=%0d required 01", o.ready, o.timed_out);
        end
        n_cmp++;
        if (o.bits !== 36'h123456789) begin
            n_fail++; $display("FAIL single_bits: got %h required 123456789", o.bits);
        end
        n_cmp++;
        if (o.en_first != 1 || o.en_cnt != 2) begin
            n_fail++; $display("FAIL single_enable: got first=%0d count=%0d required 1/2", o.en_first, o.en_cnt);
        end
        n_cmp++;
        if (o.done_cnt != 1 || o.err_cnt != 0 || o.evt_id !== id) begin
            n_fail++; $display("FAIL single_done: got done=%0d err=%0d id=%b required 1/0/%b",
                               o.done_cnt, o.err_cnt, o.evt_id, id);
        end
        n_cmp++;
        if (o.gap_busy != 8 || o.hold_bad || o.extra_ready) begin
            n_fail++; $display("FAIL single_gap: got gap=%0d hold_bad=%0d extra=%0d required 8/0/0",
                               o.gap_busy, o.hold_bad, o.extra_ready);
        end
    endtask

    task automatic test_contention();
        obs_t o;
        logic id;
        rst = 1'b1; step(); rst = 1'b0; model_fav = 1'b0;
        for (int f = 0; f < 4; f++) begin
            id = model_grant(2'b11);
            do_frame(2'b11, {4'($urandom), 32'($urandom)}, {4'($urandom), 32'($urandom)}, 0, 10, 1'b1, o);
            n_cmp++;
            if (o.timed_out || o.ready !== {id, ~id} || id !== 1'(f % 2)) begin
                n_fail++; $display("FAIL contention_grant%0d: got %b required %b", f, o.ready, {id, ~id});
            end
            n_cmp++;
            if (o.both || o.extra_ready || o.id !== id) begin
                n_fail++; $display("FAIL contention_onehot%0d: got both=%0d extra=%0d id=%b required 0/0/%b",
                                   f, o.both, o.extra_ready, o.id, id);
            end
        end
        req_valid = 2'b00;
        step();
    endtask

    task automatic test_back_to_back();
        obs_t o;
        logic [35:0] d0;
        for (int f = 0; f < 3; f++) begin
            d0 = {4'($urandom), 32'($urandom)};
            void'(model_grant(2'b01));
            do_frame(2'b01, d0, {4'($urandom), 32'($urandom)}, 0, int'($urandom_range(3, 30)), 1'b1, o);
            n_cmp++;
            if (o.timed_out || o.wait_cyc != 1 || o.bits !== d0) begin
                n_fail++; $display("FAIL b2b_grant%0d: got wait=%0d bits=%h required 1/%h", f, o.wait_cyc, o.bits, d0);
            end
            n_cmp++;
            if (o.gap_busy != 8 || o.done_cnt != 1 || o.extra_ready) begin
                n_fail++; $display("FAIL b2b_gap%0d: got gap=%0d done=%0d extra=%0d required 8/1/0",
                                   f, o.gap_busy, o.done_cnt, o.extra_ready);
            end
        end
        req_valid = 2'b00;
        step();
    endtask

    task automatic test_start_timeout();
        obs_t o;
        logic id;
        tx_complete = 1'b1;
        id = model_grant(2'b10);
        do_frame(2'b10, {4'($urandom), 32'($urandom)}, {4'($urandom), 32'($urandom)}, -1, -1, 1'b0, o);
        n_cmp++;
        if (o.timed_out || o.en_cnt != 4 || o.err_cyc - o.en_first != 4) begin
            n_fail++; $display("FAIL start_timeout_enable: got en=%0d err_at=%0d required 4/4",
                               o.en_cnt, o.err_cyc - o.en_first);
        end
        n_cmp++;
        if (o.err_cnt != 1 || o.done_cnt != 0 || o.evt_id !== id || o.gap_busy != 8) begin
            n_fail++; $display("FAIL start_timeout_err: got err=%0d done=%0d id=%b gap=%0d required 1/0/%b/8",
                               o.err_cnt, o.done_cnt, o.evt_id, o.gap_busy, id);
        end
    endtask

    task automatic test_busy_timeout();
        obs_t o;
        int seen;
        void'(model_grant(2'b01));
        do_frame(2'b01, {4'($urandom), 32'($urandom)}, {4'($urandom), 32'($urandom)}, 0, -1, 1'b0, o);
        n_cmp++;
        if (o.timed_out || o.err_cnt != 1 || o.done_cnt != 0 || o.err_cyc - (o.low_start + 1) != 63) begin
            n_fail++; $display("FAIL busy_timeout_err: got err=%0d done=%0d after=%0d required 1/0/63",
                               o.err_cnt, o.done_cnt, o.err_cyc - (o.low_start + 1));
        end
        n_cmp++;
        if (o.en_cnt != 1) begin
            n_fail++; $display("FAIL busy_timeout_enable: got %0d enable cycles required 1", o.en_cnt);
        end
        seen = 0;
        req_valid = 2'b01;
        repeat (6) begin
            step();
            if (req_ready !== 2'b00 || busy !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_fail++; $display("FAIL no_grant_while_tx_busy: got %0d bad cycles required 0", seen);
        end
        req_valid = 2'b00; tx_complete = 1'b1;
        step();
        void'(model_grant(2'b10));
        do_frame(2'b10, {4'($urandom), 32'($urandom)}, {4'($urandom), 32'($urandom)}, 0, 63, 1'b0, o);
        n_cmp++;
        if (o.timed_out || o.done_cnt != 1 || o.err_cnt != 0) begin
            n_fail++; $display("FAIL busy_edge_63: got done=%0d err=%0d required 1/0", o.done_cnt, o.err_cnt);
        end
        void'(model_grant(2'b10));
        do_frame(2'b10, {4'($urandom), 32'($urandom)}, {4'($urandom), 32'($urandom)}, 0, 64, 1'b0, o);
        n_cmp++;
        if (o.timed_out || o.done_cnt != 0 || o.err_cnt != 1) begin
            n_fail++; $display("FAIL busy_edge_64: got done=%0d err=%0d required 0/1", o.done_cnt, o.err_cnt);
        end
        tx_complete = 1'b1;
    endtask

    task automatic test_mid_frame_reset();
        obs_t o;
        bit got;
        int bad;
        void'(model_grant(2'b01));
        do_frame(2'b01, {4'($urandom), 32'($urandom)}, {4'($urandom), 32'($urandom)}, 0, 5, 1'b0, o);
        req_valid = 2'b01;
        got = 1'b0;
        for (int w = 0; w < 16 && !got; w++) begin step(); got = (req_ready !== 2'b00); end
        req_valid = 2'b00;
        for (int w = 0; w < 8 && got; w++) begin step(); if (tx_enable === 1'b1) break; end
        tx_complete = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (!got || busy !== 1'b1 || tx_enable !== 1'b0) begin
            n_fail++; $display("FAIL midreset_setup: got grant=%0d busy=%b en=%b required 1/1/0", got, busy, tx_enable);
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if ({req_ready, tx_enable, tx_bits, frame_done, done_id, err_pulse, busy} !== 43'd0) begin
            n_fail++; $display("FAIL midreset_outputs: got %h required 0",
                               {req_ready, tx_enable, tx_bits, frame_done, done_id, err_pulse, busy});
        end
        rst = 1'b0; tx_complete = 1'b1; model_fav = 1'b0;
        bad = 0;
        repeat (12) begin
            step();
            if (frame_done !== 1'b0 || err_pulse !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++; $display("FAIL midreset_quiet: got %0d bad cycles required 0", bad);
        end
        void'(model_grant(2'b11));
        do_frame(2'b11, {4'($urandom), 32'($urandom)}, {4'($urandom), 32'($urandom)}, 0, 6, 1'b0, o);
        n_cmp++;
        if (o.timed_out || o.ready !== 2'b01) begin
            n_fail++; $display("FAIL midreset_pointer: got %b required 01", o.ready);
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic [1:0] rv;
        logic [35:0] d0, d1;
        int drop, low;
        logic id;
        bit exp_err;
        for (int i = 0; i < 24; i++) begin
            rv = 2'($urandom_range(1, 3));
            d0 = {4'($urandom), 32'($urandom)};
            d1 = {4'($urandom), 32'($urandom)};
            drop = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 2));
            low = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(2, 70));
            id = model_grant(rv);
            exp_err = (drop < 0) || (low < 0) || (low > 63);
            do_frame(rv, d0, d1, drop, low, 1'b0, o);
            tx_complete = 1'b1;
            n_cmp++;
            if (o.timed_out || o.ready !== {id, ~id} || o.bits !== (id ? d1 : d0)) begin
                n_fail++; $display("FAIL rand%0d_grant: got ready=%b bits=%h required %b/%h",
                                   i, o.ready, o.bits, {id, ~id}, (id ? d1 : d0));
            end
            n_cmp++;
            if (o.done_cnt != int'(!exp_err) || o.err_cnt != int'(exp_err) || o.evt_id !== id) begin
                n_fail++; $display("FAIL rand%0d_outcome: got done=%0d err=%0d id=%b required %0d/%0d/%b",
                                   i, o.done_cnt, o.err_cnt, o.evt_id, !exp_err, exp_err, id);
            end
            n_cmp++;
            if (o.en_cnt != ((drop < 0) ? 4 : drop + 1) || o.en_first != 1) begin
                n_fail++; $display("FAIL rand%0d_enable: got count=%0d first=%0d required %0d/1",
                                   i, o.en_cnt, o.en_first, (drop < 0) ? 4 : drop + 1);
            end
            n_cmp++;
            if (o.gap_busy != 8 || o.both || o.extra_ready || o.hold_bad) begin
                n_fail++; $display("FAIL rand%0d_gap: got gap=%0d both=%0d extra=%0d hold=%0d required 8/0/0/0",
                                   i, o.gap_busy, o.both, o.extra_ready, o.hold_bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_contention();
        test_back_to_back();
        test_start_timeout();
        test_busy_timeout();
        test_mid_frame_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
